// File: rtl/z80_ld_sequencer.sv
// -----------------------------------------------------------------------------
// z80_ld_sequencer
//
// Control stage in front of the Z80 register bank. It fetches opcode bytes over
// the shared 8-bit data bus, decodes the 8-bit load group and drives the bank's
// one-hot write/read strobes.
//
// Supported: LD r,r' (two moves through temp W), LD r,n, NOP, HALT.
// Optional:  LD SP,HL (0xF9) when the macro Z80_LD_SP_HL_EN is defined;
//            otherwise 0xF9 decodes as illegal.
//
// Parameters:
//   WAIT_MAX  cycles mem_rd may stay high without mem_ack before abort (1..255)
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   data_bus  shared data bus (observed only, valid while mem_ack=1)
//   mem_ack   memory read acknowledge
//   mem_rd    memory read request
//   pc_inc    one-cycle pulse, PC advances by one
//   WE / RE   one-hot register write / read strobes (bank index map)
//   halted    sticky, set by HALT (0x76)
//   illegal   one-cycle pulse on an unsupported opcode
//   timeout   one-cycle pulse on a handshake abort
// -----------------------------------------------------------------------------
module z80_ld_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_bus,
    input  logic        mem_ack,
    output logic        mem_rd,
    output logic        pc_inc,
    output logic [15:0] WE,
    output logic [15:0] RE,
    output logic        halted,
    output logic        illegal,
    output logic        timeout
);

    // Bank index map (only the entries this sequencer touches directly)
    localparam logic [3:0] IDX_W  = 4'd0;
    localparam logic [3:0] IDX_H  = 4'd8;
    localparam logic [3:0] IDX_L  = 4'd9;
    localparam logic [3:0] IDX_SP = 4'd12;

    // Last no-ack cycle before the handshake is abandoned
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MOVE1,
        S_MOVE2,
        S_IMM,
        S_HALT,
        S_SPH,
        S_SPL
    } state_t;

    typedef enum logic [2:0] {
        K_NOP,
        K_HALT,
        K_MOVE,
        K_IMM,
        K_SPHL,
        K_ILL
    } kind_t;

    // Z80 r-field to bank index. Field 110 is (HL); callers never pass it.
    function automatic logic [3:0] reg_idx(input logic [2:0] f);
        logic [3:0] idx;
        case (f)
            3'b000:  idx = 4'd4;   // B
            3'b001:  idx = 4'd5;   // C
            3'b010:  idx = 4'd6;   // D
            3'b011:  idx = 4'd7;   // E
            3'b100:  idx = 4'd8;   // H
            3'b101:  idx = 4'd9;   // L
            3'b111:  idx = 4'd2;   // A
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    function automatic kind_t classify(input logic [7:0] op);
        kind_t k;
        if (op == 8'h00)
            k = K_NOP;
        else if (op == 8'h76)
            k = K_HALT;
        else if (op[7:6] == 2'b01 && op[5:3] != 3'b110 && op[2:0] != 3'b110)
            k = K_MOVE;
        else if (op[7:6] == 2'b00 && op[2:0] == 3'b110 && op[5:3] != 3'b110)
            k = K_IMM;
`ifdef Z80_LD_SP_HL_EN
        else if (op == 8'hF9)
            k = K_SPHL;
`endif
        else
            k = K_ILL;
        return k;
    endfunction

    state_t      state;
    logic [7:0]  opcode;
    logic [7:0]  wait_cnt;
    logic [15:0] we_q;
    logic [15:0] re_q;
    kind_t       op_kind;
    logic        ack_ok;
    logic [3:0]  src_idx;
    logic [3:0]  dst_idx;

    assign op_kind = classify(opcode);
    assign src_idx = reg_idx(opcode[2:0]);
    assign dst_idx = reg_idx(opcode[5:3]);

    // An ack only counts while a request is outstanding.
    assign ack_ok = mem_rd & mem_ack;
    assign pc_inc = ack_ok;

    // LD r,n writes the operand straight off the bus in its ack cycle, so that
    // one strobe cannot be registered; every other strobe is.
    always_comb begin
        WE = we_q;
        if (state == S_IMM && ack_ok)
            WE = we_q | onehot(dst_idx);
    end

    assign RE = re_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            opcode   <= 8'h00;
            wait_cnt <= 8'h00;
            mem_rd   <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
            we_q     <= 16'h0000;
            re_q     <= 16'h0000;
        end else begin
            illegal <= 1'b0;
            timeout <= 1'b0;
            we_q    <= 16'h0000;
            re_q    <= 16'h0000;

            case (state)
                S_FETCH, S_IMM: begin
                    if (!mem_rd) begin
                        // Idle fetch after reset, after an abort or after an
                        // operand read: raise the request now.
                        mem_rd <= 1'b1;
                    end else if (mem_ack) begin
                        mem_rd   <= 1'b0;
                        wait_cnt <= 8'h00;
                        if (state == S_FETCH) begin
                            opcode  <= data_bus;
                            state   <= S_DECODE;
                            // Flag lands in the decode cycle of this opcode.
                            illegal <= (classify(data_bus) == K_ILL);
                        end else begin
                            // Operand written combinationally this cycle; the
                            // request drops for a cycle before the next fetch.
                            state <= S_FETCH;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Abort: no pc_inc was issued, so the retry reads the
                        // same address.
                        mem_rd   <= 1'b0;
                        wait_cnt <= 8'h00;
                        timeout  <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_DECODE: begin
                    case (op_kind)
                        K_HALT: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        K_MOVE: begin
                            state <= S_MOVE1;
                            re_q  <= onehot(src_idx);
                            we_q  <= onehot(IDX_W);
                        end
                        K_IMM: begin
                            state  <= S_IMM;
                            mem_rd <= 1'b1;
                        end
                        K_SPHL: begin
                            // High byte first: the bank's SP shifts it in.
                            state <= S_SPH;
                            re_q  <= onehot(IDX_H);
                            we_q  <= onehot(IDX_SP);
                        end
                        default: begin
                            // NOP and illegal opcodes go straight to fetch.
                            state  <= S_FETCH;
                            mem_rd <= 1'b1;
                        end
                    endcase
                end

                S_MOVE1: begin
                    state <= S_MOVE2;
                    re_q  <= onehot(IDX_W);
                    we_q  <= onehot(dst_idx);
                end

                S_SPH: begin
                    state <= S_SPL;
                    re_q  <= onehot(IDX_L);
                    we_q  <= onehot(IDX_SP);
                end

                S_MOVE2, S_SPL: begin
                    state  <= S_FETCH;
                    mem_rd <= 1'b1;
                end

                S_HALT: begin
                    // Only reset leaves HALT.
                    state <= S_HALT;
                end

                default: begin
                    state  <= S_FETCH;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/z80_ld_sequencer.md
Name: z80_ld_sequencer

Overview:
- Control stage directly upstream of the Z80 register bank. Fetches opcode bytes from memory over the shared 8-bit data bus, decodes the 8-bit load group, and drives the bank's one-hot WE/RE strobes.
- Supported: LD r,r' through temp W; LD r,n; NOP; HALT.
- Owns the memory read handshake, PC-increment request and timeout detection.

Parameters:
- WAIT_MAX, 15: maximum cycles mem_rd stays high without mem_ack before abort. Range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- data_bus  input  8  shared data bus, observed only; memory drives it while mem_ack=1
- mem_ack  input  1  memory read acknowledge; byte valid on data_bus this cycle
- mem_rd  output  1  memory read request
- pc_inc  output  1  one-cycle pulse: PC advances by one
- WE  output  16  one-hot register write strobes, bank index map
- RE  output  16  one-hot register read strobes, bank index map
- halted  output  1  sticky; set by HALT (0x76)
- illegal  output  1  one-cycle pulse on an unsupported opcode
- timeout  output  1  one-cycle pulse on a handshake abort

Behaviour:
- Bank index map: W=0, Z=1, A=2, F=3, B=4, C=5, D=6, E=7, H=8, L=9, IX=10, IY=11, SP=12, PC=13. Bits 14 and 15 are never asserted.
- Z80 r-field to index: 000 B, 001 C, 010 D, 011 E, 100 H, 101 L, 111 A. Field 110 means (HL), which is unsupported.
- Reset (reset=0, asynchronous): all outputs 0, state=FETCH, wait counter=0, opcode register=0. The first mem_rd asserts on the first rising edge after release.
- States: FETCH, DECODE, MOVE1, MOVE2, IMM, HALT.
- Handshake, in FETCH and IMM:
  - mem_rd=1 from state entry until the cycle mem_ack=1 is sampled, inclusive.
  - The byte is captured on that edge; pc_inc pulses in the same cycle.
  - mem_rd=0 from the next cycle.
  - mem_ack while mem_rd=0 is ignored.
- Timeout: the counter counts cycles with mem_rd=1 and no ack. When it reaches WAIT_MAX:
  - timeout pulses for 1 cycle and mem_rd drops.
  - No WE/pc_inc is issued; state goes to FETCH and the same address is retried (PC unchanged).
- DECODE, 1 cycle, no strobes:
  - 0x00: go to FETCH.
  - 0x76: go to HALT.
  - 01 ddd sss, neither field 110: go to MOVE1.
  - 00 ddd 110, ddd≠110: go to IMM.
  - Anything else: illegal=1 for this cycle, then FETCH.
- MOVE1: RE[src]=1, WE[W]=1 for 1 cycle.
- MOVE2: RE[W]=1, WE[dst]=1 for 1 cycle, then FETCH.
- LD r,r' latency: fetch, then 3 cycles. LD A,A is executed normally.
- IMM: WE[dst]=1 only in the mem_ack cycle, while memory drives the operand on the bus. Then FETCH.
- HALT: no strobes, no mem_rd; halted=1. Only reset exits.
- Invariants:
  - At most one WE bit and one RE bit high per cycle.
  - WE and RE never name the same index.
  - RE is never high while mem_rd=1, to avoid bus contention.
- Reset mid-operation: strobes drop immediately; partial transfers are abandoned.

Optional Feature:
- Macro: Z80_LD_SP_HL_EN.
- Defined: opcode 0xF9 (LD SP,HL) decodes to two extra states:
  - SPH: RE[H], WE[SP].
  - SPL: RE[L], WE[SP].
  - Each lasts 1 cycle, then FETCH. The bank's SP shifts in the high byte first.
- Undefined: 0xF9 is illegal (1-cycle pulse, then FETCH). No SP strobes ever.

Test Plan:
- Reset release, memory supplies 0x00 with ack after 2 cycles → mem_rd high 3 cycles, one pc_inc, no WE/RE, next fetch begins.
- Opcode 0x78 (LD A,B) → MOVE1: RE[4], WE[0]; MOVE2: RE[0], WE[2]; then mem_rd=1.
- Opcodes 0x3E, 0x5A (LD A,0x5A) → two pc_inc pulses. WE[2]=1 exactly in the operand ack cycle, with data_bus=0x5A.
- WAIT_MAX=4, no ack → timeout pulse after 4 mem_rd cycles, no pc_inc, fetch retried; then ack 0x41 (LD B,C) → RE[5]/WE[0], RE[0]/WE[4].
- Opcode 0x76 → halted=1, mem_rd stays 0 for 20 cycles; reset low mid-HALT → halted=0, fetch restarts.
- 0x46 (LD B,(HL)) → illegal pulse, no strobes. 0xF9 with Z80_LD_SP_HL_EN → RE[8]/WE[12], RE[9]/WE[12]; without it → illegal pulse.
